// File: rtl/led_chase_pkg.sv
// led_chase_pkg: shared state encoding, default sizes and step helper for the LED chase checker
package led_chase_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_IDX_W    = 4;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LAP_W    = 8;

    // The chase moves one step toward bit 0, wrapping from 0 back to the MSB
    function automatic int unsigned next_idx(input int unsigned prev, input int unsigned width);
        return (prev == 0) ? width - 1 : prev - 1;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: returns the lit bit index of a bus and whether exactly one bit is set
module onehot_decoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    // Highest set bit wins; the value only matters when the bus is one-hot
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec[i]) idx = IDX_W'(i);
    end

    assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/led_chase_checker.sv
// led_chase_checker: tracks the one-hot LED chase, declares lock, counts laps and flags errors
module led_chase_checker
    import led_chase_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LAP_W    = DEF_LAP_W
) (
    input  logic             clkdiv,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_in,
    input  logic             sample_en,
    input  logic             clr_err,
    output logic [IDX_W-1:0] pos,
    output logic             pos_valid,
    output logic             locked,
    output logic [LAP_W-1:0] lap_count,
    output logic             onehot_err,
    output logic             step_err,
    output logic             err_sticky
);

    state_t           state;
    logic [3:0]       streak;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] exp_idx;
    logic             is_onehot;
    logic             good_step;
    logic             err_now;

    onehot_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
        .vec       (led_in),
        .idx       (idx),
        .is_onehot (is_onehot)
    );

    assign exp_idx   = IDX_W'(next_idx(32'(pos), WIDTH));
    assign good_step = idx == exp_idx;
    assign err_now   = sample_en && (!is_onehot || (state != IDLE && !good_step));

    // Tracking FSM: position, streak, lock, lap counting and error pulses
    always_ff @(posedge clkdiv) begin
        if (rst) begin
            state      <= IDLE;
            streak     <= '0;
            pos        <= '0;
            pos_valid  <= 1'b0;
            locked     <= 1'b0;
            lap_count  <= '0;
            onehot_err <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            onehot_err <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= err_now ? 1'b1 : clr_err ? 1'b0 : err_sticky;
            if (sample_en) begin
                if (!is_onehot) begin
                    onehot_err <= 1'b1;
                    pos_valid  <= 1'b0;
                    locked     <= 1'b0;
                    streak     <= '0;
                    state      <= IDLE;
                end else begin
                    pos       <= idx;
                    pos_valid <= 1'b1;
                    case (state)
                        IDLE: begin
                            streak <= '0;
                            state  <= ACQUIRE;
                        end
                        ACQUIRE: begin
                            if (!good_step) begin
                                step_err <= 1'b1;
                                streak   <= '0;
                            end else if (streak == 4'(LOCK_CNT - 1)) begin
                                streak <= 4'(LOCK_CNT);
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end else begin
                                streak <= streak + 4'd1;
                            end
                        end
                        LOCKED: begin
                            if (!good_step) begin
                                step_err <= 1'b1;
                                locked   <= 1'b0;
                                streak   <= '0;
                                state    <= ACQUIRE;
                            end else if (pos == '0) begin
                                lap_count <= lap_count + 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
